// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core: data width, register
// index constants and the ALU control codes used alongside the register file.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_RA   = 5'd1;
   localparam reg_idx_t REG_SP   = 5'd2;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_ctrl_e;

endpackage

// File: rtl/reg_file.sv
// Integer register file: x1..x(NREGS-1) stored, x0 hard-wired to zero, three
// combinational read ports and one clocked write port. Define REGFILE_BYPASS_EN for write-through forwarding.
module reg_file #(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int NREGS = 32
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   RegWrite,
   input  logic [riscv_pkg::REG_ADDR_W-1:0]       WriteReg,
   input  logic [XLEN-1:0]                        WriteData,
   input  logic [riscv_pkg::REG_ADDR_W-1:0]       ReadReg1,
   input  logic [riscv_pkg::REG_ADDR_W-1:0]       ReadReg2,
   output logic [XLEN-1:0]                        ReadData1,
   output logic [XLEN-1:0]                        ReadData2,
   input  logic [riscv_pkg::REG_ADDR_W-1:0]       DbgReg,
   output logic [XLEN-1:0]                        DbgData,
   output logic [31:0]                            WriteCount
);

   import riscv_pkg::*;

   localparam int ADDR_W = $clog2(NREGS);

   // Indices that name a real, stored register: not x0 and inside NREGS.
   function automatic logic idx_valid(input reg_idx_t idx);
      return (idx != REG_ZERO) && (int'(idx) < NREGS);
   endfunction

   logic [XLEN-1:0] regs [1:NREGS-1];
   logic            write_ok;
   reg_idx_t        rd_idx [3];

   assign write_ok = RegWrite && idx_valid(WriteReg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         WriteCount <= '0;
      end else if (write_ok) begin
         regs[WriteReg[ADDR_W-1:0]] <= WriteData;
         WriteCount <= WriteCount + 32'd1;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_en;

   // Forwarding never applies during reset so every port reads zero then.
   assign fwd_en = rst_n && write_ok;
`endif

   assign rd_idx[0] = ReadReg1;
   assign rd_idx[1] = ReadReg2;
   assign rd_idx[2] = DbgReg;

   for (genvar p = 0; p < 3; p++) begin : g_read
      logic [XLEN-1:0] data;

      always_comb begin
         data = '0;
         if (idx_valid(rd_idx[p])) begin
            data = regs[rd_idx[p][ADDR_W-1:0]];
         end
`ifdef REGFILE_BYPASS_EN
         if (fwd_en && (rd_idx[p] == WriteReg)) begin
            data = WriteData;
         end
`endif
      end
   end

   assign ReadData1 = g_read[0].data;
   assign ReadData2 = g_read[1].data;
   assign DbgData   = g_read[2].data;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed register-file scenarios plus
// randomized traffic compared every cycle against an array-based model.
module tb_reg_file;

   import riscv_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        RegWrite = 1'b0;
   logic [4:0]  WriteReg = '0;
   logic [31:0] WriteData = '0;
   logic [4:0]  ReadReg1 = '0;
   logic [4:0]  ReadReg2 = '0;
   logic [4:0]  DbgReg = '0;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] DbgData;
   logic [31:0] WriteCount;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model_regs [32];
   logic [31:0] model_count;

   reg_file #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .RegWrite(RegWrite),
      .WriteReg(WriteReg),
      .WriteData(WriteData),
      .ReadReg1(ReadReg1),
      .ReadReg2(ReadReg2),
      .ReadData1(ReadData1),
      .ReadData2(ReadData2),
      .DbgReg(DbgReg),
      .DbgData(DbgData),
      .WriteCount(WriteCount)
   );

   always #10 clk = ~clk;

   // Architectural state: what the register file must hold after each edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            model_regs[i] <= '0;
         end
         model_count <= '0;
      end else if (RegWrite && (WriteReg != 5'd0)) begin
         model_regs[WriteReg] <= WriteData;
         model_count <= model_count + 32'd1;
      end
   end

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (BYPASS && rst_n && RegWrite && (WriteReg == a)) return WriteData;
      return model_regs[a];
   endfunction

   function automatic logic [31:0] alu(input alu_ctrl_e ctl, input logic [31:0] a, input logic [31:0] b);
      case (ctl)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_NOR: return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Every cycle, away from the rising edge, all outputs must match the model.
   always @(negedge clk) begin
      check_output("model_rd1", ReadData1, exp_read(ReadReg1));
      check_output("model_rd2", ReadData2, exp_read(ReadReg2));
      check_output("model_dbg", DbgData, exp_read(DbgReg));
      check_output("model_count", WriteCount, model_count);
   end

   // Caller is positioned just after a rising edge; returns just after the commit edge.
   task automatic do_write(input logic [4:0] idx, input logic [31:0] d);
      RegWrite = 1'b1;
      WriteReg = idx;
      WriteData = d;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
   endtask

   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input int cycles);
      for (int n = 0; n < cycles; n++) begin
         @(posedge clk);
         #1;
         RegWrite  = ($urandom_range(0, 3) != 0);
         WriteReg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         WriteData = $urandom;
         ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         ReadReg2  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         DbgReg    = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 49) == 0) begin
            #1 rst_n = 1'b0;
            #10 rst_n = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
   endtask

   logic [31:0] res;

   initial begin
      #1 rst_n = 1'b0;
      #1;
      ReadReg1 = 5'd31;
      DbgReg = 5'd5;
      #1;
      check_output("reset_rd1", ReadData1, 32'h0);
      check_output("reset_dbg", DbgData, 32'h0);
      check_output("reset_count", WriteCount, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_write(5'd5, 32'hDEADBEEF);
      ReadReg1 = 5'd5;
      ReadReg2 = 5'd5;
      #1;
      check_output("basic_rd1", ReadData1, 32'hDEADBEEF);
      check_output("basic_rd2", ReadData2, 32'hDEADBEEF);
      check_output("basic_count", WriteCount, 32'd1);

      do_write(5'd0, 32'hFFFFFFFF);
      ReadReg1 = 5'd0;
      #1;
      check_output("x0_rd1", ReadData1, 32'h0);
      check_output("x0_count", WriteCount, 32'd1);

      do_write(5'd7, 32'h11111111);
      RegWrite = 1'b1;
      WriteReg = 5'd7;
      WriteData = 32'h22222222;
      ReadReg1 = 5'd7;
      #1;
      check_output("hazard_before", ReadData1, BYPASS ? 32'h22222222 : 32'h11111111);
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      #1;
      check_output("hazard_after", ReadData1, 32'h22222222);
      check_output("hazard_count", WriteCount, 32'd3);

      do_write(5'd1, 32'h12345678);
      do_write(5'd2, 32'h12345678);
      ReadReg1 = REG_RA;
      ReadReg2 = REG_SP;
      #1;
      res = alu(ALU_SUB, ReadData1, ReadData2);
      check_output("alu_sub_result", res, 32'd0);
      check_output("alu_sub_zero", {31'd0, res == 32'd0}, 32'd1);
      do_write(5'd2, 32'h00000001);
      do_write(5'd1, 32'hFFFFFFFF);
      #1;
      check_output("alu_slt_result", alu(ALU_SLT, ReadData1, ReadData2), 32'd1);

      apply_stimulus(600);

      RegWrite = 1'b1;
      WriteReg = 5'd9;
      WriteData = 32'hAAAA5555;
      ReadReg1 = 5'd9;
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_output("lost_write_rd1", ReadData1, 32'h0);
      check_output("lost_write_count", WriteCount, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      #1;
      check_output("first_write_rd1", ReadData1, 32'hAAAA5555);
      check_output("first_write_count", WriteCount, 32'd1);

      pulse_reset();
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i));
      end
      for (int i = 1; i < 32; i++) begin
         DbgReg = 5'(i);
         #1;
         check_output("fill_dbg", DbgData, 32'(i));
      end
      check_output("fill_count", WriteCount, 32'd31);

      @(posedge clk);
      #1 rst_n = 1'b0;
      for (int i = 1; i < 5; i++) begin
         ReadReg1 = 5'(i);
         ReadReg2 = 5'(i + 8);
         DbgReg = 5'(i + 16);
         #1;
         check_output("midreset_rd1", ReadData1, 32'h0);
         check_output("midreset_rd2", ReadData2, 32'h0);
         check_output("midreset_dbg", DbgData, 32'h0);
      end
      check_output("midreset_count", WriteCount, 32'd0);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
